lcm_from_gcd: RTL
=================

LCM_FROM_GCD -- requirements
Module: lcm_from_gcd

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand and result width.
REQ-002 SHALL have port sys_clk  input  1  rising-edge clock.
REQ-003 SHALL have port sys_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port a  input  DATA_W  first operand, same value fed to the upstream gcd block.
REQ-006 SHALL have port b  input  DATA_W  second operand.
REQ-007 SHALL have port g  input  DATA_W  gcd result (return_val of the upstream gcd block).
REQ-008 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port lcm  output  DATA_W  low DATA_W bits of (a/g)*b.
REQ-011 SHALL have port overflow  output  1  true product exceeded DATA_W bits.
REQ-012 SHALL have port div_zero  output  1  g was zero.

Function
REQ-013 SHALL implement a one-hot FSM with states IDLE, LOAD, DIV, MUL, DONE.
REQ-014 In IDLE with start=1, SHALL latch a, b, g into internal registers and enter LOAD on that edge.
REQ-015 In LOAD, if latched g==0, SHALL set lcm=0, overflow=0, div_zero=1 and enter DONE.
REQ-016 In LOAD, if g!=0, SHALL clear the step counter, remainder and quotient and enter DIV.
REQ-017 DIV SHALL perform restoring division a/g, one quotient bit per cycle, MSB first, for exactly DATA_W cycles, then enter MUL.
REQ-018 MUL SHALL perform shift-add multiplication of quotient by b into a 2*DATA_W accumulator, one bit of b per cycle, for exactly DATA_W cycles, then enter DONE.
REQ-019 On entering DONE, lcm SHALL equal accumulator[DATA_W-1:0] and overflow SHALL equal OR of accumulator[2*DATA_W-1:DATA_W]; div_zero=0.
REQ-020 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-021 Latency for g!=0: done SHALL be high in the cycle beginning 2*DATA_W+2 edges after the edge that accepted start (66 for DATA_W=32).
REQ-022 Latency for g==0: done SHALL be high in the cycle beginning 2 edges after the accepting edge.
REQ-023 start SHALL be ignored while busy=1 or in DONE; no queueing.
REQ-024 Changes on a, b, g after acceptance SHALL NOT affect the current result.
REQ-025 lcm, overflow, div_zero SHALL hold their values from DONE until the next result is written.
REQ-026 a==0 or b==0 with g!=0 SHALL yield lcm=0, overflow=0 after the full latency.
REQ-027 g not dividing a SHALL use the floor quotient; there is no error flag.
REQ-028 busy SHALL equal 1 in LOAD, DIV and MUL, and 0 in IDLE and DONE.

Reset
REQ-029 sys_rst_n low SHALL force IDLE, step counter=0, busy=0, done=0, lcm=0, overflow=0, div_zero=0, and clear the internal registers.
REQ-030 Reset asserted mid-operation SHALL abort immediately with no done pulse; the first start after release SHALL be processed normally.

Structure
REQ-031 State encodings (5-bit one-hot) and DATA_W default SHALL live in shared package gcd_pkg.
REQ-032 The divider datapath SHALL be sub-module lcm_divider (start, DATA_W-cycle restoring divide, quotient out); the multiplier stays inline.

Verification
REQ-033 a=12, b=18, g=6 -> done at +66 cycles, lcm=36, overflow=0, div_zero=0.
REQ-034 a=7, b=5, g=0 -> done at +2 cycles, lcm=0, div_zero=1; busy high for exactly 1 cycle.
REQ-035 a=0xFFFFFFFF, b=0xFFFFFFFE, g=1 -> lcm=0x00000002, overflow=1.
REQ-036 Second start pulse and changed a/b/g at +10 cycles during a=12, b=18, g=6 -> single done, lcm=36.
REQ-037 sys_rst_n pulsed low at +30 cycles -> no done, all outputs 0; then a=4, b=6, g=2 -> lcm=12 at +66.
REQ-038 Back-to-back start on the cycle after done -> accepted; second result correct at +66.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the lcm_from_gcd block: default width and one-hot FSM state encodings.
package gcd_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_LOAD = 5'b00010,
    S_DIV  = 5'b00100,
    S_MUL  = 5'b01000,
    S_DONE = 5'b10000
  } state_e;

endpackage

// File: rtl/lcm_divider.sv
// Restoring divider producing one quotient bit per step_i, MSB first.
// Caller issues start_i once, then exactly DATA_W step_i cycles with stable divisor_i.
module lcm_divider
  import gcd_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] quotient_o
);

  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W:0]   shifted_c;
  logic [DATA_W:0]   divisor_ext_c;

  // One restoring step: bring in the next dividend bit and subtract when it fits.
  always_comb begin
    dvd_d         = dvd_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    shifted_c     = {rem_q, dvd_q[DATA_W-1]};
    divisor_ext_c = {1'b0, divisor_i};
    if (start_i) begin
      dvd_d = dividend_i;
      rem_d = '0;
      quo_d = '0;
    end else if (step_i) begin
      dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
      if (shifted_c >= divisor_ext_c) begin
        rem_d = DATA_W'(shifted_c - divisor_ext_c);
        quo_d = {quo_q[DATA_W-2:0], 1'b1};
      end else begin
        rem_d = shifted_c[DATA_W-1:0];
        quo_d = {quo_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dvd_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
    end else begin
      dvd_q <= dvd_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign quotient_o = quo_q;

endmodule

// File: rtl/lcm_from_gcd.sv
// Computes lcm = (a / g) * b from an upstream gcd result using a serial divider
// followed by a serial shift-add multiplier; done pulses one cycle after the DONE state.
module lcm_from_gcd
  import gcd_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] g,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] lcm,
  output logic              overflow,
  output logic              div_zero
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   g_q, g_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   lcm_q, lcm_d;
  logic                ovf_q, ovf_d;
  logic                dz_q, dz_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                div_start_c;
  logic                div_step_c;
  logic [DATA_W:0]     sum_c;
  logic [DATA_W-1:0]   quo_c;

  lcm_divider #(.DATA_W(DATA_W)) u_divider (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start_i    (div_start_c),
    .step_i     (div_step_c),
    .dividend_i (a_q),
    .divisor_i  (g_q),
    .quotient_o (quo_c)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: state_d = (g_q == '0) ? S_DONE : S_DIV;
      S_DIV:  if (cnt_q == CNT_LAST) state_d = S_MUL;
      S_MUL:  if (cnt_q == CNT_LAST) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values; multiplier accumulates into the high half and shifts right.
  always_comb begin
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    g_d         = g_q;
    acc_d       = acc_q;
    lcm_d       = lcm_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    div_start_c = 1'b0;
    div_step_c  = 1'b0;
    sum_c       = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (b_q[0] ? {1'b0, quo_c} : '0);
    busy_d      = (state_d == S_LOAD) || (state_d == S_DIV) || (state_d == S_MUL);
    done_d      = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d = a;
          b_d = b;
          g_d = g;
        end
      end
      S_LOAD: begin
        cnt_d = '0;
        acc_d = '0;
        if (g_q == '0) begin
          lcm_d = '0;
          ovf_d = 1'b0;
          dz_d  = 1'b1;
        end else begin
          div_start_c = 1'b1;
        end
      end
      S_DIV: begin
        div_step_c = 1'b1;
        cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
      S_MUL: begin
        acc_d = {sum_c, acc_q[DATA_W-1:1]};
        b_d   = {1'b0, b_q[DATA_W-1:1]};
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          lcm_d = acc_d[DATA_W-1:0];
          ovf_d = |acc_d[2*DATA_W-1:DATA_W];
          dz_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      g_q    <= '0;
      acc_q  <= '0;
      lcm_q  <= '0;
      ovf_q  <= 1'b0;
      dz_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      g_q    <= g_d;
      acc_q  <= acc_d;
      lcm_q  <= lcm_d;
      ovf_q  <= ovf_d;
      dz_q   <= dz_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign lcm      = lcm_q;
  assign overflow = ovf_q;
  assign div_zero = dz_q;

endmodule
